// File: rtl/m_seq_pkg.sv
// Shared definitions for the m-sequence (1+x^2+x^3+x^4+x^8) transmit generator and receive checker.
package m_seq_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int unsigned HIST_W   = 8;
    localparam logic [7:0]  TAPS_DEF = 8'h8E;
    localparam int unsigned SEQ_LEN  = 255;
    localparam int unsigned CNT_W    = 32;

    // Increment that holds at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/m_seq_pred.sv
// History register and bit predictor; shifts either the received bit or its own prediction.
module m_seq_pred
    import m_seq_pkg::*;
#(
    parameter logic [HIST_W-1:0] TAPS = TAPS_DEF
) (
    input  logic              clk,
    input  logic              areset_n,
    input  logic              shift_en,
    input  logic              use_pred,
    input  logic              rx_bit,
    output logic [HIST_W-1:0] h,
    output logic              pred_c
);

    assign pred_c = ^(h & TAPS);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            h <= '0;
        end else if (shift_en) begin
            h <= {h[HIST_W-2:0], (use_pred ? pred_c : rx_bit)};
        end
    end

endmodule

// File: rtl/m_seq_checker.sv
// Receive-side m-sequence checker: lock, flywheel tracking, bit/error statistics.
// Define M_SEQ_CHK_SYNC_EN to add 2-flop synchronisers on bit_clk and din.
module m_seq_checker
    import m_seq_pkg::*;
#(
    parameter logic [HIST_W-1:0] TAPS      = TAPS_DEF,
    parameter int unsigned       SYNC_GOOD = 16,
    parameter int unsigned       WIN       = 256,
    parameter int unsigned       LOSS_THR  = 32
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             bit_clk,
    input  logic             din,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned FILL_W = $clog2(HIST_W + 1);
    localparam int unsigned GOOD_W = $clog2(SYNC_GOOD + 1);
    localparam int unsigned WIN_W  = $clog2(WIN);
    localparam int unsigned WERR_W = $clog2(LOSS_THR + 1);

    logic              bc_s;
    logic              rx_bit;
    logic              bc_q;
    logic              stb;
    logic [HIST_W-1:0] h;
    logic              pred_c;
    logic              mism;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nxt;
    logic [HIST_W-1:0] h_nxt;
    logic [GOOD_W-1:0] good;
    logic [WIN_W-1:0]  win;
    logic [WERR_W-1:0] werr;
    state_t            state;

`ifdef M_SEQ_CHK_SYNC_EN
    logic [1:0] bc_sync;
    logic [1:0] d_sync;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            bc_sync <= '0;
            d_sync  <= '0;
        end else begin
            bc_sync <= {bc_sync[0], bit_clk};
            d_sync  <= {d_sync[0], din};
        end
    end

    assign bc_s   = bc_sync[1];
    assign rx_bit = d_sync[1];
`else
    assign bc_s   = bit_clk;
    assign rx_bit = din;
`endif

    // Rising-edge detect on the (optionally synchronised) bit clock
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            bc_q <= 1'b0;
        end else begin
            bc_q <= bc_s;
        end
    end

    assign stb      = bc_s & ~bc_q;
    assign mism     = rx_bit ^ pred_c;
    assign fill_nxt = (fill == FILL_W'(HIST_W)) ? fill : fill + FILL_W'(1);
    assign h_nxt    = {h[HIST_W-2:0], rx_bit};

    // In LOCKED the predictor feeds itself so line errors do not enter the history
    m_seq_pred #(
        .TAPS (TAPS)
    ) u_pred (
        .clk      (clk),
        .areset_n (areset_n),
        .shift_en (stb),
        .use_pred (state == LOCKED),
        .rx_bit   (rx_bit),
        .h        (h),
        .pred_c   (pred_c)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state     <= HUNT;
            fill      <= '0;
            good      <= '0;
            win       <= '0;
            werr      <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            bit_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (stb) begin
                case (state)
                    HUNT: begin
                        fill <= fill_nxt;
                        if (fill_nxt == FILL_W'(HIST_W) && h_nxt != '0) begin
                            state <= CHECK;
                            good  <= '0;
                        end
                    end
                    CHECK: begin
                        if (mism) begin
                            state <= HUNT;
                            fill  <= '0;
                        end else if (good == GOOD_W'(SYNC_GOOD - 1)) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                            win    <= '0;
                            werr   <= '0;
                        end else begin
                            good <= good + GOOD_W'(1);
                        end
                    end
                    LOCKED: begin
                        err_pulse <= mism;
                        if (mism && werr == WERR_W'(LOSS_THR - 1)) begin
                            state  <= HUNT;
                            locked <= 1'b0;
                            fill   <= '0;
                            good   <= '0;
                            win    <= '0;
                            werr   <= '0;
                        end else if (win == WIN_W'(WIN - 1)) begin
                            win  <= '0;
                            werr <= '0;
                        end else begin
                            win  <= win + WIN_W'(1);
                            werr <= werr + WERR_W'(mism);
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                        fill   <= '0;
                    end
                endcase
            end

            // clr takes priority over a coincident strobe
            if (clr) begin
                bit_cnt <= '0;
                err_cnt <= '0;
            end else if (stb && state == LOCKED) begin
                bit_cnt <= sat_inc(bit_cnt);
                if (mism) begin
                    err_cnt <= sat_inc(err_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_m_seq_checker.sv
// Directed self-checking bench for m_seq_checker (honours M_SEQ_CHK_SYNC_EN for strobe latency).
`timescale 1ns/1ps
module tb_m_seq_checker;

`ifdef M_SEQ_CHK_SYNC_EN
    localparam int STB_LAT = 3;
`else
    localparam int STB_LAT = 1;
`endif
    localparam int HALF = 24;

    logic        clk = 1'b0;
    logic        areset_n;
    logic        bit_clk;
    logic        din;
    logic        clr;
    logic        locked;
    logic        err_pulse;
    logic [31:0] bit_cnt;
    logic [31:0] err_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    int          pulse_cnt = 0;
    int          p0;
    logic [7:0]  g;
    logic [31:0] clr_bc, clr_ec;
    logic        clr_ep;
    logic        relocked;

    m_seq_checker dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .bit_clk   (bit_clk),
        .din       (din),
        .clr       (clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .bit_cnt   (bit_cnt),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (err_pulse) pulse_cnt <= pulse_cnt + 1;

    initial begin
        #1500us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One 50-clk bit; optionally pulse clr exactly in the strobe cycle and capture outputs after it
    task automatic drive_bit(input logic b, input logic with_clr);
        int high_left;
        high_left = HALF;
        @(negedge clk) din = b;
        @(negedge clk) bit_clk = 1'b1;
        if (with_clr) begin
            repeat (STB_LAT - 1) @(negedge clk);
            clr = 1'b1;
            @(negedge clk);
            clr    = 1'b0;
            clr_bc = bit_cnt;
            clr_ec = err_cnt;
            clr_ep = err_pulse;
            high_left = HALF - STB_LAT;
        end
        repeat (high_left) @(negedge clk);
        bit_clk = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    function automatic logic next_gen();
        logic b;
        b = ^(g & 8'h8E);
        g = {g[6:0], b};
        return b;
    endfunction

    task automatic send_seq(input int n, input logic inv);
        for (int i = 0; i < n; i++) drive_bit(next_gen() ^ inv, 1'b0);
    endtask

    task automatic pulse_reset();
        @(negedge clk) areset_n = 1'b0;
        @(negedge clk) areset_n = 1'b1;
    endtask

    initial begin
        areset_n = 1'b0;
        bit_clk  = 1'b0;
        din      = 1'b0;
        clr      = 1'b0;
        g        = 8'h01;
        repeat (3) @(negedge clk);
        check("rst_locked", 32'(locked), 0);
        check("rst_pulse", 32'(err_pulse), 0);
        check("rst_bit_cnt", bit_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        areset_n = 1'b1;

        // Constant zero never leaves HUNT
        for (int i = 0; i < 100; i++) drive_bit(1'b0, 1'b0);
        check("zero_locked", 32'(locked), 0);
        check("zero_bit_cnt", bit_cnt, 0);
        check("zero_err_cnt", err_cnt, 0);

        // Clean acquisition from seed 8'h01
        pulse_reset();
        send_seq(23, 1'b0);
        check("acq_bit23", 32'(locked), 0);
        send_seq(1, 1'b0);
        check("acq_bit24", 32'(locked), 1);
        check("acq_bit_cnt", bit_cnt, 0);

        send_seq(1000, 1'b0);
        check("run_bit_cnt", bit_cnt, 1000);
        check("run_err_cnt", err_cnt, 0);
        check("run_locked", 32'(locked), 1);

        // Single line error, flywheel keeps tracking
        p0 = pulse_cnt;
        send_seq(1, 1'b1);
        check("single_err_cnt", err_cnt, 1);
        check("single_locked", 32'(locked), 1);
        check("single_pulses", 32'(pulse_cnt - p0), 1);
        send_seq(30, 1'b0);
        check("after_err_cnt", err_cnt, 1);
        check("after_bit_cnt", bit_cnt, 1031);
        check("after_pulses", 32'(pulse_cnt - p0), 1);

        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        @(negedge clk);
        check("clr_bit_cnt", bit_cnt, 0);
        check("clr_err_cnt", err_cnt, 0);

        // Burst of 40 inverted bits: lock lost on the 32nd error
        send_seq(31, 1'b1);
        check("burst31_locked", 32'(locked), 1);
        check("burst31_err_cnt", err_cnt, 31);
        send_seq(1, 1'b1);
        check("burst32_locked", 32'(locked), 0);
        check("burst32_err_cnt", err_cnt, 32);
        send_seq(8, 1'b1);
        check("burst40_locked", 32'(locked), 0);
        check("burst40_err_cnt", err_cnt, 32);

        relocked = 1'b0;
        for (int i = 0; i < 64 && !relocked; i++) begin
            send_seq(1, 1'b0);
            relocked = locked;
        end
        check("relock_seen", 32'(relocked), 1);
        check("relock_err_cnt", err_cnt, 32);

        // clr coincident with an errored strobe
        send_seq(3, 1'b0);
        drive_bit(~next_gen(), 1'b1);
        check("clrstb_bit_cnt", clr_bc, 0);
        check("clrstb_err_cnt", clr_ec, 0);
        check("clrstb_pulse", 32'(clr_ep), 1);
        send_seq(1, 1'b0);
        check("clrstb_next_bit", bit_cnt, 1);
        check("clrstb_next_err", err_cnt, 0);

        // Reset while locked
        @(negedge clk) areset_n = 1'b0;
        @(negedge clk);
        check("midrst_locked", 32'(locked), 0);
        check("midrst_pulse", 32'(err_pulse), 0);
        check("midrst_bit_cnt", bit_cnt, 0);
        check("midrst_err_cnt", err_cnt, 0);
        @(negedge clk) areset_n = 1'b1;
        send_seq(23, 1'b0);
        check("midrst_bit23", 32'(locked), 0);
        send_seq(1, 1'b0);
        check("midrst_bit24", 32'(locked), 1);

        // Mismatch during CHECK restarts acquisition
        pulse_reset();
        send_seq(11, 1'b0);
        send_seq(1, 1'b1);
        send_seq(23, 1'b0);
        check("chkerr_bit35", 32'(locked), 0);
        send_seq(1, 1'b0);
        check("chkerr_bit36", 32'(locked), 1);
        check("chkerr_err_cnt", err_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
